mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter bus_width, default 32, data and address width of all bus channels.
REQ-002 Parameter depth, default 1024, number of bus_width-bit words in the array (power of two).
REQ-003 Parameter read_latency, default 1, cycles from read-address accept to rdata_valid assertion (>=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 raddr_valid  input  1  read address offered by initiator.
REQ-007 raddr_ready  output  1  responder accepts read address.
REQ-008 raddr  input  bus_width  read byte address.
REQ-009 rdata_valid  output  1  read data offered.
REQ-010 rdata_ready  input  1  initiator accepts read data.
REQ-011 rdata  output  bus_width  read data word.
REQ-012 waddr_valid / waddr_ready  input / output  1 each  write-address handshake.
REQ-013 waddr  input  bus_width  write byte address.
REQ-014 wdata_valid / wdata_ready  input / output  1 each  write-data handshake.
REQ-015 wdata  input  bus_width  write data word.
REQ-016 err  output  1  sticky out-of-range access flag (see Configuration).

Function
REQ-017 A transfer on any channel SHALL occur only on a rising edge with valid and ready both high.
REQ-018 Word index SHALL be address bits [log2(depth)+1:2]; address bits [1:0] are ignored.
REQ-019 The read path SHALL be a FSM: IDLE -> WAIT -> RESP -> IDLE.
REQ-020 raddr_ready SHALL be high only in IDLE; a raddr transfer moves to WAIT and loads a countdown with read_latency-1.
REQ-021 In WAIT the countdown SHALL decrement each cycle; at zero the array word is captured into rdata and the state moves to RESP.
REQ-022 With read_latency=1 the WAIT state SHALL last one cycle, so rdata_valid asserts on the cycle after raddr accept.
REQ-023 In RESP rdata_valid SHALL be high and rdata stable until an rdata transfer, then return to IDLE; only one read outstanding.
REQ-024 A new raddr SHALL NOT be accepted in the cycle of the rdata transfer.
REQ-025 waddr and wdata SHALL each be captured into an independent holding register; arrival in either order or the same cycle is legal.
REQ-026 waddr_ready SHALL be low while the address holding register is full; wdata_ready likewise for the data register.
REQ-027 When both holding registers are full, the array write SHALL occur on the next edge and both registers clear on that edge.
REQ-028 Back-to-back writes SHALL sustain one write per two cycles.
REQ-029 Read and write SHALL operate concurrently; a write committed on the same edge that captures rdata SHALL NOT be visible (old data returned).

Reset
REQ-030 On rst low: read FSM to IDLE, countdown 0, both holding registers empty, rdata 0, err 0.
REQ-031 Reset outputs: raddr_ready 0 while rst low, 1 after release; rdata_valid 0; waddr_ready 1; wdata_ready 1.
REQ-032 Reset mid-read SHALL drop rdata_valid immediately; reset mid-write SHALL discard any held address/data.
REQ-033 Array contents SHALL NOT be reset.

Configuration
REQ-034 Macro MEM_RESPONDER_ADDR_CHECK_EN SHALL control address range checking.
REQ-035 Defined: address with word index >= depth (any bit above log2(depth)+1 set) returns rdata 0xDEADBEEF, write is dropped, err sets and stays 1 until reset.
REQ-036 Undefined: upper address bits ignored (wrap modulo depth), err tied 0.

Verification
REQ-037 Write waddr 0x10 wdata 0xCAFEF00D same cycle, then read 0x10 -> rdata_valid one cycle after accept (latency 1), rdata 0xCAFEF00D.
REQ-038 wdata 0x1234 three cycles before waddr 0x20 -> wdata_ready low until write commit; read 0x20 returns 0x1234.
REQ-039 read_latency=3, read with rdata_ready held low 5 cycles -> rdata_valid at accept+3, rdata stable, raddr_ready low until transfer.
REQ-040 Assert rst low while in RESP -> rdata_valid 0 asynchronously; after release raddr_ready 1, err 0.
REQ-041 With MEM_RESPONDER_ADDR_CHECK_EN, depth 1024, read 0x1000 -> rdata 0xDEADBEEF, err 1; without macro, same read returns word 0.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory responder with split read/write handshake channels
// Optional feature: MEM_RESPONDER_ADDR_CHECK_EN enables out-of-range address checking and the err flag.
module mem_responder #(
  parameter int bus_width    = 32,
  parameter int depth        = 1024,
  parameter int read_latency = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raddr_valid,
  output logic                 raddr_ready,
  input  logic [bus_width-1:0] raddr,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [bus_width-1:0] rdata,
  input  logic                 waddr_valid,
  output logic                 waddr_ready,
  input  logic [bus_width-1:0] waddr,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [bus_width-1:0] wdata,
  output logic                 err
);

  localparam int idx_w = $clog2(depth);
  localparam int cnt_w = (read_latency > 1) ? $clog2(read_latency) : 1;

  typedef enum logic [1:0] {st_idle, st_wait, st_resp} rd_state_t;

  logic [bus_width-1:0] mem [depth];

  rd_state_t            rd_state;
  logic [cnt_w-1:0]     rd_cnt;
  logic [idx_w-1:0]     rd_idx;
  logic                 rd_oor;

  logic                 aw_full;
  logic [idx_w-1:0]     aw_idx;
  logic                 aw_oor;
  logic                 w_full;
  logic [bus_width-1:0] w_data;

  logic                 raddr_oor;
  logic                 waddr_oor;
  logic                 wr_commit;
  logic                 unused_addr_bits;

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  assign raddr_oor        = |raddr[bus_width-1:idx_w+2];
  assign waddr_oor        = |waddr[bus_width-1:idx_w+2];
  assign unused_addr_bits = ^{raddr[1:0], waddr[1:0]};
`else
  assign raddr_oor        = 1'b0;
  assign waddr_oor        = 1'b0;
  assign unused_addr_bits = ^{raddr[1:0], waddr[1:0],
                              raddr[bus_width-1:idx_w+2], waddr[bus_width-1:idx_w+2]};
`endif

  // Only one read in flight: the address channel opens solely in idle and never while reset is held.
  assign raddr_ready = rst && (rd_state == st_idle);
  assign waddr_ready = !aw_full;
  assign wdata_ready = !w_full;
  assign wr_commit   = aw_full && w_full;

  // Read path: accept address, count down the latency, present data until the initiator takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state    <= st_idle;
      rd_cnt      <= '0;
      rd_idx      <= '0;
      rd_oor      <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      case (rd_state)
        st_idle: begin
          if (raddr_valid) begin
            rd_idx   <= raddr[idx_w+1:2];
            rd_oor   <= raddr_oor;
            rd_cnt   <= cnt_w'(read_latency - 1);
            rd_state <= st_wait;
          end
        end
        st_wait: begin
          if (rd_cnt == '0) begin
            // Nonblocking read of mem returns pre-write contents if a write commits this same edge.
            rdata       <= rd_oor ? bus_width'(32'hDEAD_BEEF) : mem[rd_idx];
            rdata_valid <= 1'b1;
            rd_state    <= st_resp;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        st_resp: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            rd_state    <= st_idle;
          end
        end
        default: rd_state <= st_idle;
      endcase
    end
  end

  // Write path: independent address/data holding registers, both cleared on the commit edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
      aw_oor  <= 1'b0;
      w_full  <= 1'b0;
      w_data  <= '0;
    end else if (wr_commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (waddr_valid && !aw_full) begin
        aw_full <= 1'b1;
        aw_idx  <= waddr[idx_w+1:2];
        aw_oor  <= waddr_oor;
      end
      if (wdata_valid && !w_full) begin
        w_full <= 1'b1;
        w_data <= wdata;
      end
    end
  end

  // Array write; contents survive reset, and out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_commit && !aw_oor) begin
      mem[aw_idx] <= w_data;
    end
  end

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  logic err_q;

  // Sticky flag: set by any out-of-range address transfer, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((raddr_valid && raddr_ready && raddr_oor) ||
                 (waddr_valid && waddr_ready && waddr_oor)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - table-driven self-checking bench for mem_responder
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        raddr_valid = 1'b0, rdata_ready = 1'b0, waddr_valid = 1'b0, wdata_valid = 1'b0;
  logic [31:0] raddr = '0, waddr = '0, wdata = '0;
  logic        raddr_ready, rdata_valid, waddr_ready, wdata_ready, err;
  logic [31:0] rdata;

  logic        b_raddr_valid = 1'b0, b_rdata_ready = 1'b0, b_waddr_valid = 1'b0, b_wdata_valid = 1'b0;
  logic [31:0] b_raddr = '0, b_waddr = '0, b_wdata = '0;
  logic        b_raddr_ready, b_rdata_valid, b_waddr_ready, b_wdata_ready, b_err;
  logic [31:0] b_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  mem_responder #(.bus_width(32), .depth(1024), .read_latency(1)) dut (
    .clk(clk), .rst(rst),
    .raddr_valid(raddr_valid), .raddr_ready(raddr_ready), .raddr(raddr),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .waddr_valid(waddr_valid), .waddr_ready(waddr_ready), .waddr(waddr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .err(err)
  );

  mem_responder #(.bus_width(32), .depth(1024), .read_latency(3)) dut3 (
    .clk(clk), .rst(rst),
    .raddr_valid(b_raddr_valid), .raddr_ready(b_raddr_ready), .raddr(b_raddr),
    .rdata_valid(b_rdata_valid), .rdata_ready(b_rdata_ready), .rdata(b_rdata),
    .waddr_valid(b_waddr_valid), .waddr_ready(b_waddr_ready), .waddr(b_waddr),
    .wdata_valid(b_wdata_valid), .wdata_ready(b_wdata_ready), .wdata(b_wdata),
    .err(b_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    waddr = a; wdata = d; waddr_valid = 1'b1; wdata_valid = 1'b1;
    tick();
    waddr_valid = 1'b0; wdata_valid = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    int n = 0;
    raddr = a; raddr_valid = 1'b1;
    while (!raddr_ready && n < 50) begin tick(); n++; end
    tick();
    raddr_valid = 1'b0;
    lat = 0;
    while (!rdata_valid && lat < 20) begin tick(); lat++; end
    d = rdata;
    rdata_ready = 1'b1;
    tick();
    rdata_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, held;
    int lat;
    int n;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 32'h0000_0014, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5};
    vecs[4] = '{1'b0, 32'h0000_0FFC, 32'hA5A5_A5A5};
    vecs[5] = '{1'b0, 32'h0000_0017, 32'h0000_0001};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h1111_1111};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h1111_1111};
    vecs[8] = '{1'b0, 32'h0000_0014, 32'h0000_0001};

    // Reset state
    tick(); tick();
    check("rst_raddr_ready", {31'd0, raddr_ready}, 32'd0);
    check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("rst_waddr_ready", {31'd0, waddr_ready}, 32'd1);
    check("rst_wdata_ready", {31'd0, wdata_ready}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b1;
    tick();
    check("rel_raddr_ready", {31'd0, raddr_ready}, 32'd1);

    // Table of writes and reads at latency 1
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data);
        check($sformatf("vec%0d_waddr_ready", i), {31'd0, waddr_ready}, 32'd1);
      end else begin
        do_read(vecs[i].addr, d, lat);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].data);
        check($sformatf("vec%0d_latency", i), lat, 32'd1);
      end
    end

    // Data three cycles ahead of address
    wdata = 32'h0000_1234; wdata_valid = 1'b1;
    tick();
    wdata_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("early_wdata_ready_%0d", i), {31'd0, wdata_ready}, 32'd0);
      tick();
    end
    check("early_wdata_ready_2", {31'd0, wdata_ready}, 32'd0);
    waddr = 32'h20; waddr_valid = 1'b1;
    tick();
    waddr_valid = 1'b0;
    check("early_both_full_wdata_ready", {31'd0, wdata_ready}, 32'd0);
    check("early_both_full_waddr_ready", {31'd0, waddr_ready}, 32'd0);
    tick();
    check("early_commit_wdata_ready", {31'd0, wdata_ready}, 32'd1);
    check("early_commit_waddr_ready", {31'd0, waddr_ready}, 32'd1);
    do_read(32'h20, d, lat);
    check("early_read", d, 32'h0000_1234);

    // Write committing on the rdata capture edge is not visible to that read
    do_write(32'h30, 32'h0BAD_0001);
    raddr = 32'h30; raddr_valid = 1'b1;
    waddr = 32'h30; wdata = 32'h600D_0002; waddr_valid = 1'b1; wdata_valid = 1'b1;
    tick();
    raddr_valid = 1'b0; waddr_valid = 1'b0; wdata_valid = 1'b0;
    tick();
    check("collide_valid", {31'd0, rdata_valid}, 32'd1);
    check("collide_old_data", rdata, 32'h0BAD_0001);
    rdata_ready = 1'b1;
    tick();
    rdata_ready = 1'b0;
    do_read(32'h30, d, lat);
    check("collide_new_data", d, 32'h600D_0002);

    // Latency 3 with stalled initiator
    b_waddr = 32'h8; b_wdata = 32'h5555_AAAA; b_waddr_valid = 1'b1; b_wdata_valid = 1'b1;
    tick();
    b_waddr_valid = 1'b0; b_wdata_valid = 1'b0;
    tick();
    b_raddr = 32'h8; b_raddr_valid = 1'b1;
    check("l3_raddr_ready_idle", {31'd0, b_raddr_ready}, 32'd1);
    tick();
    b_raddr_valid = 1'b0;
    n = 0;
    while (!b_rdata_valid && n < 20) begin
      check($sformatf("l3_raddr_ready_wait%0d", n), {31'd0, b_raddr_ready}, 32'd0);
      tick();
      n++;
    end
    check("l3_latency", n, 32'd3);
    held = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("l3_hold_valid%0d", i), {31'd0, b_rdata_valid}, 32'd1);
      check($sformatf("l3_hold_rdata%0d", i), b_rdata, held);
      check($sformatf("l3_hold_raddr_ready%0d", i), {31'd0, b_raddr_ready}, 32'd0);
      tick();
    end
    b_rdata_ready = 1'b1;
    tick();
    b_rdata_ready = 1'b0;
    check("l3_after_xfer_valid", {31'd0, b_rdata_valid}, 32'd0);
    check("l3_after_xfer_raddr_ready", {31'd0, b_raddr_ready}, 32'd1);

    // Out-of-range read
    do_read(32'h1000, d, lat);
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    check("oor_rdata", d, 32'hDEAD_BEEF);
    check("oor_err", {31'd0, err}, 32'd1);
`else
    check("wrap_rdata", d, 32'h1111_1111);
    check("wrap_err", {31'd0, err}, 32'd0);
`endif

    // Reset while in RESP with write data held
    raddr = 32'h10; raddr_valid = 1'b1;
    wdata = 32'h0000_0077; wdata_valid = 1'b1;
    tick();
    raddr_valid = 1'b0; wdata_valid = 1'b0;
    check("mid_wdata_held", {31'd0, wdata_ready}, 32'd0);
    tick();
    check("mid_resp_valid", {31'd0, rdata_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("mid_rst_raddr_ready", {31'd0, raddr_ready}, 32'd0);
    check("mid_rst_wdata_ready", {31'd0, wdata_ready}, 32'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("post_rst_raddr_ready", {31'd0, raddr_ready}, 32'd1);
    check("post_rst_err", {31'd0, err}, 32'd0);
    check("post_rst_rdata", rdata, 32'd0);

    // Address alone must wait: the pre-reset data was discarded
    waddr = 32'h44; waddr_valid = 1'b1;
    tick();
    waddr_valid = 1'b0;
    tick();
    check("discard_addr_held", {31'd0, waddr_ready}, 32'd0);
    wdata = 32'h0000_0099; wdata_valid = 1'b1;
    tick();
    wdata_valid = 1'b0;
    tick();
    do_read(32'h44, d, lat);
    check("discard_read", d, 32'h0000_0099);
    do_read(32'h10, d, lat);
    check("mem_survives_reset", d, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
